// File: rtl/sync_fifo_lvl_pkg.sv
// Shared definitions for the level-reporting synchronous FIFO.
package sync_fifo_lvl_pkg;

    typedef enum logic {
        FIFO_MODE_REG  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_bits(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_lvl_if.sv
// Data/status bundle between a FIFO user (master) and sync_fifo_lvl (slave).
interface sync_fifo_lvl_if
    import sync_fifo_lvl_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 128
);
    logic                         flush_i;
    logic [WIDTH-1:0]             wdata_i;
    logic                         we_i;
    logic                         re_i;
    logic [WIDTH-1:0]             rdata_o;
    logic                         rvalid_o;
    logic                         full_o;
    logic                         empty_o;
    logic                         almost_full_o;
    logic                         almost_empty_o;
    logic [ptr_bits(DEPTH)-1:0]   count_o;
    logic                         overflow_o;
    logic                         underflow_o;

    modport master (
        output flush_i, wdata_i, we_i, re_i,
        input  rdata_o, rvalid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, wdata_i, we_i, re_i,
        output rdata_o, rvalid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sync_fifo_lvl_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_lvl
    import sync_fifo_lvl_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 1,
    parameter int unsigned FWFT      = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sync_fifo_lvl_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_bits(DEPTH);
    localparam logic [PW-1:0] AFULL_LV  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_LV = PW'(AEMPTY_TH);

    logic [PW-1:0]    w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, count;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             full, empty, rd_ok, wr_ok;
    logic [WIDTH-1:0] mem_rdata;

    assign count = w_ptr_q - r_ptr_q;
    assign empty = (w_ptr_q == r_ptr_q);
    assign full  = (w_ptr_q[PW-1] != r_ptr_q[PW-1]) &&
                   (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);
    // A full FIFO still takes a write when a pop frees the slot this cycle.
    assign rd_ok = bus.re_i & ~empty;
    assign wr_ok = bus.we_i & (~full | rd_ok);

    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (bus.flush_i) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            w_ptr_d = w_ptr_q + PW'(wr_ok);
            r_ptr_d = r_ptr_q + PW'(rd_ok);
            ovf_d   = ovf_q | (bus.we_i & ~wr_ok);
            unf_d   = unf_q | (bus.re_i & empty);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_ok & ~bus.flush_i),
        .waddr_i (w_ptr_q[AW-1:0]),
        .wdata_i (bus.wdata_i),
        .raddr_i (r_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    generate
        if (FWFT == 32'(FIFO_MODE_FWFT)) begin : g_fwft
            assign bus.rdata_o  = empty ? '0 : mem_rdata;
            assign bus.rvalid_o = ~empty;
        end else begin : g_reg
            logic [WIDTH-1:0] rdata_q, rdata_d;
            logic             rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = 1'b0;
                if (!bus.flush_i && rd_ok) begin
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign bus.rdata_o  = rdata_q;
            assign bus.rvalid_o = rvalid_q;
        end
    endgenerate

    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.almost_full_o  = (count >= AFULL_LV);
    assign bus.almost_empty_o = (count <= AEMPTY_LV);
    assign bus.count_o        = count;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = unf_q;
endmodule
